// File: rtl/cva6_wrapper_pkg.sv
// cva6_wrapper_pkg: SoC address map, target indices and peripheral-arbiter types shared across the CVA6 wrapper.
package cva6_wrapper_pkg;
  typedef enum logic [1:0] {EXTERNAL = 2'd0, PLIC = 2'd1, CLINT = 2'd2, DEBUG = 2'd3} axi_slaves_t;
  localparam logic [63:0] DebugBase = 64'h0000_0000;
  localparam logic [63:0] DebugLength = 64'h0000_1000;
  localparam logic [63:0] ClintBase = 64'h0200_0000;
  localparam logic [63:0] ClintLength = 64'h000C_0000;
  localparam logic [63:0] PlicBase = 64'h0C00_0000;
  localparam logic [63:0] PlicLength = 64'h03FF_FFFF;
  localparam logic [63:0] ExtBase = 64'h1000_0000;
  localparam logic [63:0] ExtLength = 64'hEFFF_FFFF;
  localparam int unsigned PeriphTimeoutCycles = 1024;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP, ARB_ERR} periph_arb_state_e;
  // Below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds.
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] len);
    return (addr - base) < len;
  endfunction
  function automatic logic [1:0] onehot4_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/cva6_periph_addr_decode.sv
// cva6_periph_addr_decode: maps a byte address onto a one-hot peripheral target plus a hit flag.
module cva6_periph_addr_decode
  import cva6_wrapper_pkg::*;
(
  input  logic [63:0] addr_i,
  output logic [3:0]  tgt_o,
  output logic        hit_o
);
  assign tgt_o[EXTERNAL] = in_range(addr_i, ExtBase, ExtLength);
  assign tgt_o[PLIC]     = in_range(addr_i, PlicBase, PlicLength);
  assign tgt_o[CLINT]    = in_range(addr_i, ClintBase, ClintLength);
  assign tgt_o[DEBUG]    = in_range(addr_i, DebugBase, DebugLength);
  assign hit_o = |tgt_o;
endmodule

// File: rtl/cva6_periph_bus_arbiter.sv
// cva6_periph_bus_arbiter: round-robin share of the peripheral bus between CVA6 and debug,
// one transfer outstanding, with decode-miss and timeout error responses.
module cva6_periph_bus_arbiter
  import cva6_wrapper_pkg::*;
#(
  parameter int unsigned NumInit       = 2,
  parameter int unsigned NumTgt        = 4,
  parameter int unsigned TimeoutCycles = PeriphTimeoutCycles
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumInit-1:0]           ini_req_i,
  input  logic [NumInit-1:0]           ini_we_i,
  input  logic [NumInit-1:0][63:0]     ini_addr_i,
  input  logic [NumInit-1:0][63:0]     ini_wdata_i,
  input  logic [NumInit-1:0][7:0]      ini_be_i,
  output logic [NumInit-1:0]           ini_gnt_o,
  output logic [NumInit-1:0]           ini_rvalid_o,
  output logic [63:0]                  ini_rdata_o,
  output logic                         ini_err_o,
  output logic [NumTgt-1:0]            tgt_req_o,
  output logic                         tgt_we_o,
  output logic [63:0]                  tgt_addr_o,
  output logic [63:0]                  tgt_wdata_o,
  output logic [7:0]                   tgt_be_o,
  input  logic [NumTgt-1:0]            tgt_gnt_i,
  input  logic [NumTgt-1:0]            tgt_rvalid_i,
  input  logic [NumTgt-1:0][63:0]      tgt_rdata_i,
  input  logic [NumTgt-1:0]            tgt_err_i
);
  localparam int unsigned TW = $clog2(TimeoutCycles);
  periph_arb_state_e state_q, state_d;
  logic          rr_q, rr_d, ini_q, ini_d, we_q, we_d, win, hit, done, tmo_last;
  logic [1:0]    tgt_q, tgt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [63:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]    be_q, be_d;
  logic [3:0]    tgt_oh;
  // On contention the initiator that did not win last time goes first.
  assign win = &ini_req_i ? ~rr_q : ini_req_i[1];
  cva6_periph_addr_decode i_decode (.addr_i(ini_addr_i[win]), .tgt_o(tgt_oh), .hit_o(hit));
  assign done = tgt_rvalid_i[tgt_q] & (state_q == ARB_RESP | tgt_gnt_i[tgt_q]);
  assign tmo_last = tmo_q == TW'(TimeoutCycles - 1);
  assign tgt_we_o = we_q;
  assign tgt_addr_o = addr_q;
  assign tgt_wdata_o = wdata_q;
  assign tgt_be_o = be_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      rr_q    <= 1'b1;
      tmo_q   <= '0;
      ini_q   <= 1'b0;
      tgt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tmo_q   <= tmo_d;
      ini_q   <= ini_d;
      tgt_q   <= tgt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    ini_d   = ini_q;
    tgt_d   = tgt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      ARB_IDLE: if (|ini_req_i) begin
        state_d = hit ? ARB_REQ : ARB_ERR;
        rr_d    = win;
        ini_d   = win;
        tgt_d   = onehot4_idx(tgt_oh);
        tmo_d   = '0;
        we_d    = ini_we_i[win];
        addr_d  = ini_addr_i[win];
        wdata_d = ini_wdata_i[win];
        be_d    = ini_be_i[win];
      end
      ARB_REQ, ARB_RESP: begin
        tmo_d   = tmo_q + 1'b1;
        state_d = done ? ARB_IDLE : tmo_last ? ARB_ERR :
                  (state_q == ARB_REQ && tgt_gnt_i[tgt_q]) ? ARB_RESP : state_q;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_comb begin
    ini_gnt_o    = '0;
    ini_rvalid_o = '0;
    ini_rdata_o  = '0;
    ini_err_o    = 1'b0;
    tgt_req_o    = '0;
    if (rst_ni) begin
      case (state_q)
        ARB_IDLE: ini_gnt_o[win] = |ini_req_i;
        ARB_REQ, ARB_RESP: begin
          tgt_req_o[tgt_q] = state_q == ARB_REQ;
          if (state_q == ARB_RESP || done) begin
            ini_rvalid_o[ini_q] = tgt_rvalid_i[tgt_q];
            ini_rdata_o         = tgt_rdata_i[tgt_q];
            ini_err_o           = tgt_err_i[tgt_q];
          end
        end
        default: begin
          ini_rvalid_o[ini_q] = 1'b1;
          ini_err_o           = 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cva6_periph_bus_arbiter.sv
// tb_cva6_periph_bus_arbiter: directed and randomized traffic against a transaction-level model of the arbiter.
module tb_cva6_periph_bus_arbiter;
  localparam int TC = 8;
  logic             clk = 1'b0, rst_n = 1'b0;
  logic [1:0]       ini_req = '0, ini_we = '0;
  logic [1:0][63:0] ini_addr = '0, ini_wdata = '0;
  logic [1:0][7:0]  ini_be = '0;
  logic [1:0]       ini_gnt_o, ini_rvalid_o;
  logic [63:0]      ini_rdata_o, tgt_addr_o, tgt_wdata_o;
  logic             ini_err_o, tgt_we_o;
  logic [3:0]       tgt_req_o;
  logic [7:0]       tgt_be_o;
  logic [3:0]       tgt_gnt = '0, tgt_rvalid = '0, tgt_err = '0;
  logic [3:0][63:0] tgt_rdata = '0;
  int n_chk = 0, n_fail = 0;

  cva6_periph_bus_arbiter #(.NumInit(2), .NumTgt(4), .TimeoutCycles(TC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ini_req_i(ini_req), .ini_we_i(ini_we), .ini_addr_i(ini_addr), .ini_wdata_i(ini_wdata), .ini_be_i(ini_be),
    .ini_gnt_o(ini_gnt_o), .ini_rvalid_o(ini_rvalid_o), .ini_rdata_o(ini_rdata_o), .ini_err_o(ini_err_o),
    .tgt_req_o(tgt_req_o), .tgt_we_o(tgt_we_o), .tgt_addr_o(tgt_addr_o), .tgt_wdata_o(tgt_wdata_o), .tgt_be_o(tgt_be_o),
    .tgt_gnt_i(tgt_gnt), .tgt_rvalid_i(tgt_rvalid), .tgt_rdata_i(tgt_rdata), .tgt_err_i(tgt_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Address map as a table of [base, base+len) windows, indexed by target number.
  function automatic int ref_tgt(input logic [63:0] a);
    logic [63:0] base [4];
    logic [63:0] len [4];
    base = '{64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0};
    len  = '{64'hEFFF_FFFF, 64'h03FF_FFFF, 64'h000C_0000, 64'h1000};
    for (int t = 0; t < 4; t++) if (a >= base[t] && a < base[t] + len[t]) return t;
    return -1;
  endfunction

  function automatic logic [63:0] pick_addr();
    logic [63:0] pool [13];
    pool = '{64'h0, 64'hFFF, 64'h1000, 64'h0200_0000, 64'h020B_FFFF, 64'h020C_0000, 64'h0C00_0000,
             64'h0FFF_FFFE, 64'h0FFF_FFFF, 64'h1000_0000, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 64'h1_0000_0000};
    return ($urandom_range(4) == 0) ? {$urandom, $urandom} : pool[$urandom_range(12)];
  endfunction

  // Transaction model: one outstanding transfer, phase 1 = awaiting target gnt, 2 = awaiting rvalid, 3 = error due.
  bit m_busy = 0, m_was_busy, m_done, m_we;
  int m_phase, m_ini, m_tgt, m_age, m_last = 1, w;
  logic [63:0] m_addr, m_wdata, e_rd;
  logic [7:0] m_be;
  logic [1:0] e_gnt, e_rv;
  logic [3:0] e_req;
  logic e_err;

  always @(negedge clk) begin
    e_gnt = '0; e_rv = '0; e_req = '0; e_rd = '0; e_err = 1'b0;
    m_was_busy = m_busy;
    if (!rst_n) begin
      m_busy = 0; m_last = 1; m_was_busy = 0;
    end else if (!m_busy) begin
      if (|ini_req) begin
        w = (&ini_req) ? 1 - m_last : (ini_req[1] ? 1 : 0);
        e_gnt[w] = 1'b1;
        m_busy = 1; m_ini = w; m_last = w; m_age = 0;
        m_tgt = ref_tgt(ini_addr[w]);
        m_we = ini_we[w]; m_addr = ini_addr[w]; m_wdata = ini_wdata[w]; m_be = ini_be[w];
        m_phase = (m_tgt < 0) ? 3 : 1;
      end
    end else if (m_phase == 3) begin
      e_rv[m_ini] = 1'b1; e_err = 1'b1; m_busy = 0;
    end else begin
      e_req[m_tgt] = (m_phase == 1);
      m_done = tgt_rvalid[m_tgt] && (m_phase == 2 || tgt_gnt[m_tgt]);
      if (m_phase == 2 || m_done) begin
        e_rv[m_ini] = tgt_rvalid[m_tgt]; e_rd = tgt_rdata[m_tgt]; e_err = tgt_err[m_tgt];
      end
      if (m_done) m_busy = 0;
      else if (m_age == TC - 1) m_phase = 3;
      else if (m_phase == 1 && tgt_gnt[m_tgt]) m_phase = 2;
      m_age++;
    end
    chk("m_gnt", 64'(ini_gnt_o), 64'(e_gnt));
    chk("m_rvalid", 64'(ini_rvalid_o), 64'(e_rv));
    chk("m_tgt_req", 64'(tgt_req_o), 64'(e_req));
    chk("m_gnt_rv_excl", 64'(ini_gnt_o & ini_rvalid_o), 64'h0);
    if (e_rv != 0 || !m_was_busy) begin
      chk("m_rdata", ini_rdata_o, e_rd);
      chk("m_err", 64'(ini_err_o), 64'(e_err));
    end
    if (e_req != 0) begin
      chk("m_tgt_addr", tgt_addr_o, m_addr);
      chk("m_tgt_wdata", tgt_wdata_o, m_wdata);
      chk("m_tgt_we_be", {55'h0, tgt_we_o, tgt_be_o}, {55'h0, m_we, m_be});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tgt();
    tgt_gnt = '0; tgt_rvalid = '0; tgt_err = '0; tgt_rdata = '0;
  endtask

  int n, nw;
  bit got;
  logic wins [4];
  logic [1:0] g;

  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("rst_gnt", 64'(ini_gnt_o), 64'h0);
    chk("rst_rvalid", 64'(ini_rvalid_o), 64'h0);
    chk("rst_tgt_req", 64'(tgt_req_o), 64'h0);
    chk("rst_rdata_err", {ini_rdata_o[62:0], ini_err_o}, 64'h0);
    step(); rst_n = 1'b1;
    // CLINT read by initiator 0
    step(); ini_req = 2'b01; ini_addr[0] = 64'h0200_BFF8; ini_we = '0;
    @(negedge clk); chk("t1_gnt", 64'(ini_gnt_o), 64'h1);
    step(); ini_req = '0; tgt_gnt = 4'b0100;
    @(negedge clk); chk("t1_tgt_req", 64'(tgt_req_o), 64'h4); chk("t1_tgt_addr", tgt_addr_o, 64'h0200_BFF8);
    step(); tgt_gnt = '0; tgt_rvalid = 4'b0100; tgt_rdata[2] = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_rvalid", 64'(ini_rvalid_o), 64'h1); chk("t1_rdata", ini_rdata_o, 64'hDEAD_BEEF); chk("t1_err", 64'(ini_err_o), 64'h0);
    step(); clear_tgt(); rst_n = 1'b0;
    // Contention from reset: grants alternate 0,1,0,1 every second cycle
    step(); step(); rst_n = 1'b1;
    ini_req = 2'b11; ini_addr[0] = 64'h0200_0000; ini_addr[1] = 64'h0200_0008; tgt_gnt = '1; tgt_rvalid = '1;
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ini_gnt_o != 0 && nw < 4) begin wins[nw] = ini_gnt_o[1]; nw++; end
      step();
    end
    chk("t2_ngrants", 64'(nw), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_winner%0d", i), 64'(wins[i]), 64'(i % 2));
    ini_req = '0; clear_tgt();
    step();
    // Initiator 1 writes just past CLINT
    ini_req = 2'b10; ini_we[1] = 1'b1; ini_addr[1] = 64'h020C_0000;
    @(negedge clk); chk("t3_gnt", 64'(ini_gnt_o), 64'h2); chk("t3_tgt_req_g", 64'(tgt_req_o), 64'h0);
    step(); ini_req = '0;
    @(negedge clk);
    chk("t3_rvalid", 64'(ini_rvalid_o), 64'h2); chk("t3_err", 64'(ini_err_o), 64'h1);
    chk("t3_rdata", ini_rdata_o, 64'h0); chk("t3_tgt_req", 64'(tgt_req_o), 64'h0);
    step();
    // PLIC never grants: timeout
    ini_req = 2'b01; ini_we = '0; ini_addr[0] = 64'h0C00_1000;
    @(negedge clk); chk("t4_gnt", 64'(ini_gnt_o), 64'h1);
    step(); ini_req = '0;
    n = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ini_rvalid_o[0]) begin
        got = 1;
        chk("t4_err", 64'(ini_err_o), 64'h1); chk("t4_rdata", ini_rdata_o, 64'h0); chk("t4_req_drop", 64'(tgt_req_o), 64'h0);
      end else if (tgt_req_o == 4'b0010) n++;
      step();
    end
    chk("t4_response_seen", 64'(got), 64'h1);
    chk("t4_req_cycles", 64'(n), 64'd8);
    @(negedge clk); chk("t4_idle_rvalid", 64'(ini_rvalid_o), 64'h0);
    step();
    // External target reports an error
    ini_req = 2'b10; ini_we = '0; ini_addr[1] = 64'h1000_0040;
    @(negedge clk); chk("t5_gnt", 64'(ini_gnt_o), 64'h2);
    step(); ini_req = '0; tgt_gnt = 4'b0001; tgt_rvalid = 4'b0001; tgt_err = 4'b0001; tgt_rdata[0] = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    chk("t5_rvalid", 64'(ini_rvalid_o), 64'h2); chk("t5_err", 64'(ini_err_o), 64'h1);
    chk("t5_rdata", ini_rdata_o, 64'h1234_5678_9ABC_DEF0);
    step(); clear_tgt();
    // Reset during RESP, then a late target response
    ini_req = 2'b01; ini_addr[0] = 64'h0200_4000;
    @(negedge clk); chk("t6_gnt", 64'(ini_gnt_o), 64'h1);
    step(); ini_req = '0; tgt_gnt = 4'b0100;
    @(negedge clk); chk("t6_tgt_req", 64'(tgt_req_o), 64'h4);
    step(); tgt_gnt = '0;
    @(negedge clk); chk("t6_resp_wait", 64'(ini_rvalid_o), 64'h0);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; tgt_rvalid = 4'b0100; tgt_rdata[2] = 64'hFEED;
    @(negedge clk);
    chk("t6_late_rvalid", 64'(ini_rvalid_o), 64'h0); chk("t6_late_rdata", ini_rdata_o, 64'h0);
    chk("t6_tgt_req", 64'(tgt_req_o), 64'h0);
    step(); clear_tgt();
    // Randomized traffic; initiators hold each request until granted
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); g = ini_gnt_o;
      step();
      for (int i = 0; i < 2; i++) begin
        if (g[i]) ini_req[i] = 1'b0;
        if (!ini_req[i] && $urandom_range(2) == 0) begin
          ini_req[i] = 1'b1; ini_we[i] = 1'($urandom); ini_addr[i] = pick_addr();
          ini_wdata[i] = {$urandom, $urandom}; ini_be[i] = 8'($urandom);
        end
      end
      tgt_gnt = (c % 500 < 80) ? 4'b0 : 4'($urandom);
      tgt_rvalid = 4'($urandom); tgt_err = 4'($urandom);
      for (int t = 0; t < 4; t++) tgt_rdata[t] = {$urandom, $urandom};
      if (c % 1000 == 999) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
